// File: rtl/trace_stack.sv
// LIFO trail of solver variable assignments with a registered zero-latency top entry,
// live decision-level tracking and sticky misuse flags.
module trace_stack #(
  parameter int VAR_BITS = 4,
  parameter int DEPTH    = 1 << VAR_BITS,
  parameter int CNT_BITS = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                push_trace,
  input  logic [VAR_BITS-1:0] var_in_trace,
  input  logic                val_in_trace,
  input  logic                type_in_trace,
  input  logic                pop_trace,
  output logic [VAR_BITS-1:0] var_out_trace,
  output logic                val_out_trace,
  output logic                type_out_trace,
  output logic                empty_trace,
  output logic                full_trace,
  output logic [CNT_BITS-1:0] count,
  output logic [CNT_BITS-1:0] decision_level,
  output logic                overflow,
  output logic                underflow
);

  localparam int IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [VAR_BITS-1:0] var_idx;
    logic                val;
    logic                dec;
  } entry_t;

  entry_t              mem_q [DEPTH];
  entry_t              top_q, top_d;
  entry_t              in_e, below_e, wr_data;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic [CNT_BITS-1:0] dl_q, dl_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                wr_en;
  logic [IDX_BITS-1:0] wr_idx;
  logic                is_empty, is_full;

  assign in_e     = '{var_idx: var_in_trace, val: val_in_trace, dec: type_in_trace};
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_BITS'(DEPTH));

  // Entry that becomes the top after a pop; read straight from the array so
  // back-to-back pops never stall.
  always_comb begin
    below_e = '0;
    if (count_q >= CNT_BITS'(2))
      below_e = mem_q[IDX_BITS'(count_q - CNT_BITS'(2))];
  end

  always_comb begin
    count_d = count_q;
    dl_d    = dl_q;
    top_d   = top_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_idx  = IDX_BITS'(count_q);
    wr_data = in_e;
    if (clear) begin
      count_d = '0;
      dl_d    = '0;
      top_d   = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      case ({push_trace, pop_trace})
        2'b10: begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            count_d = count_q + CNT_BITS'(1);
            dl_d    = dl_q + CNT_BITS'(type_in_trace);
            top_d   = in_e;
          end
        end
        2'b01: begin
          if (is_empty) begin
            unf_d = 1'b1;
          end else begin
            count_d = count_q - CNT_BITS'(1);
            dl_d    = dl_q - CNT_BITS'(top_q.dec);
            top_d   = below_e;
          end
        end
        2'b11: begin
          // Push+pop on an empty stack degenerates to a plain push.
          if (is_empty) begin
            wr_en   = 1'b1;
            count_d = count_q + CNT_BITS'(1);
            dl_d    = dl_q + CNT_BITS'(type_in_trace);
            top_d   = in_e;
          end else begin
            wr_en  = 1'b1;
            wr_idx = IDX_BITS'(count_q - CNT_BITS'(1));
            dl_d   = dl_q - CNT_BITS'(top_q.dec) + CNT_BITS'(type_in_trace);
            top_d  = in_e;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      dl_q    <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dl_q    <= dl_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Trail storage carries no reset; only entries below count are ever observed.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  assign var_out_trace  = top_q.var_idx;
  assign val_out_trace  = top_q.val;
  assign type_out_trace = top_q.dec;
  assign empty_trace    = is_empty;
  assign full_trace     = is_full;
  assign count          = count_q;
  assign decision_level = dl_q;
  assign overflow       = ovf_q;
  assign underflow      = unf_q;

endmodule

// File: tb/tb_trace_stack.sv
// Bench for trace_stack: directed scenarios plus random traffic against a queue-based model.
module tb_trace_stack;
  localparam int VB    = 4;
  localparam int DEPTH = 16;
  localparam int CB    = 5;

  typedef struct packed {
    logic [VB-1:0] v;
    logic          val;
    logic          t;
  } ent_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic          push_trace = 1'b0;
  logic [VB-1:0] var_in_trace = '0;
  logic          val_in_trace = 1'b0;
  logic          type_in_trace = 1'b0;
  logic          pop_trace = 1'b0;
  logic [VB-1:0] var_out_trace;
  logic          val_out_trace;
  logic          type_out_trace;
  logic          empty_trace;
  logic          full_trace;
  logic [CB-1:0] count;
  logic [CB-1:0] decision_level;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int passes = 0;

  ent_t mq[$];
  logic m_ovf = 1'b0;
  logic m_unf = 1'b0;

  always #5 clock = ~clock;

  trace_stack #(.VAR_BITS(VB), .DEPTH(DEPTH), .CNT_BITS(CB)) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear),
    .push_trace(push_trace), .var_in_trace(var_in_trace),
    .val_in_trace(val_in_trace), .type_in_trace(type_in_trace),
    .pop_trace(pop_trace), .var_out_trace(var_out_trace),
    .val_out_trace(val_out_trace), .type_out_trace(type_out_trace),
    .empty_trace(empty_trace), .full_trace(full_trace), .count(count),
    .decision_level(decision_level), .overflow(overflow), .underflow(underflow)
  );

  // Layout: var[19:16] val[15] type[14] empty[13] full[12] count[11:7] dl[6:2] ovf[1] unf[0]
  function automatic logic [31:0] obs_vec();
    return 32'({var_out_trace, val_out_trace, type_out_trace, empty_trace, full_trace,
                count, decision_level, overflow, underflow});
  endfunction

  function automatic logic [31:0] model_vec();
    ent_t top = (mq.size() != 0) ? mq[$] : '0;
    int dl = 0;
    foreach (mq[i]) if (mq[i].t) dl++;
    return 32'({top.v, top.val, top.t, mq.size() == 0, mq.size() == DEPTH,
                CB'(mq.size()), CB'(dl), m_ovf, m_unf});
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endfunction

  function automatic void model_step(input logic c, p, o, input ent_t e);
    if (c) begin
      model_reset();
    end else if (p && o) begin
      if (mq.size() != 0) void'(mq.pop_back());
      mq.push_back(e);
    end else if (p) begin
      if (mq.size() == DEPTH) m_ovf = 1'b1;
      else mq.push_back(e);
    end else if (o) begin
      if (mq.size() == 0) m_unf = 1'b1;
      else void'(mq.pop_back());
    end
  endfunction

  task automatic drive(input logic c, p, o, input logic [VB-1:0] v, input logic val, t);
    clear = c; push_trace = p; pop_trace = o;
    var_in_trace = v; val_in_trace = val; type_in_trace = t;
    @(posedge clock);
    model_step(c, p, o, '{v: v, val: val, t: t});
    @(negedge clock);
    clear = 1'b0; push_trace = 1'b0; pop_trace = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++;
    if (obs_vec() !== 32'h2000) $display("FAIL reset_held: got %h want %h", obs_vec(), 32'h2000);
    else passes++;
    reset_n = 1'b1;
    model_reset();
    @(negedge clock);
    checks++;
    if (obs_vec() !== model_vec()) $display("FAIL reset_release: got %h want %h", obs_vec(), model_vec());
    else passes++;
  endtask

  task automatic test_push_pop();
    logic [31:0] want [4] = '{32'h98184, 32'h70104, 32'h3C084, 32'h02000};
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 4'd3, 1, 1);
    drive(0, 1, 0, 4'd7, 0, 0);
    drive(0, 1, 0, 4'd9, 1, 0);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) drive(0, 0, 1, 0, 0, 0);
      checks++;
      if (obs_vec() !== want[i] || obs_vec() !== model_vec())
        $display("FAIL push_pop step%0d: got %h want %h", i, obs_vec(), want[i]);
      else passes++;
    end
  endtask

  task automatic test_replace();
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 4'd3, 1, 1);
    drive(0, 1, 0, 4'd7, 0, 0);
    drive(0, 1, 1, 4'd7, 1, 1);
    checks++;
    if (obs_vec() !== 32'h7C108 || obs_vec() !== model_vec())
      $display("FAIL replace: got %h want %h", obs_vec(), 32'h7C108);
    else passes++;
    drive(0, 0, 1, 0, 0, 0);
    checks++;
    if (obs_vec() !== model_vec()) $display("FAIL replace_pop: got %h want %h", obs_vec(), model_vec());
    else passes++;
  endtask

  task automatic test_full();
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++)
      drive(0, 1, 0, VB'($urandom_range(15)), 1'($urandom), 1'($urandom));
    checks++;
    if (full_trace !== 1'b1 || obs_vec() !== model_vec())
      $display("FAIL full: got %h want %h", obs_vec(), model_vec());
    else passes++;
    drive(0, 1, 0, 4'd1, 1, 1);
    checks++;
    if (overflow !== 1'b1 || count !== CB'(DEPTH) || obs_vec() !== model_vec())
      $display("FAIL overflow: got %h want %h", obs_vec(), model_vec());
    else passes++;
    drive(0, 1, 1, 4'd2, 0, 1);
    checks++;
    if (overflow !== 1'b1 || var_out_trace !== 4'd2 || obs_vec() !== model_vec())
      $display("FAIL full_replace: got %h want %h", obs_vec(), model_vec());
    else passes++;
    drive(0, 0, 1, 0, 0, 0);
    checks++;
    if (obs_vec() !== model_vec()) $display("FAIL pop_from_full: got %h want %h", obs_vec(), model_vec());
    else passes++;
  endtask

  task automatic test_underflow();
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    checks++;
    if (obs_vec() !== 32'h2001) $display("FAIL underflow: got %h want %h", obs_vec(), 32'h2001);
    else passes++;
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 4'd5, 1, 0);
    checks++;
    if (obs_vec() !== 32'h58080 || obs_vec() !== model_vec())
      $display("FAIL pushpop_empty: got %h want %h", obs_vec(), 32'h58080);
    else passes++;
  endtask

  task automatic test_clear();
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, VB'(i + 2), 1, 1);
    checks++;
    if (obs_vec() !== model_vec()) $display("FAIL pre_clear: got %h want %h", obs_vec(), model_vec());
    else passes++;
    drive(1, 1, 0, 4'd11, 1, 1);
    checks++;
    if (obs_vec() !== 32'h2000) $display("FAIL clear_prio: got %h want %h", obs_vec(), 32'h2000);
    else passes++;
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, VB'($urandom_range(15)), 1'($urandom), 1'($urandom));
    checks++;
    if (count !== CB'(5) || obs_vec() !== model_vec())
      $display("FAIL pre_reset: got %h want %h", obs_vec(), model_vec());
    else passes++;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs_vec() !== 32'h2000) $display("FAIL async_reset: got %h want %h", obs_vec(), 32'h2000);
    else passes++;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (obs_vec() !== model_vec()) $display("FAIL after_reset: got %h want %h", obs_vec(), model_vec());
    else passes++;
  endtask

  task automatic test_back_to_back();
    int r;
    logic c, p, o;
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(99);
      c = (r < 2);
      p = (r >= 2 && r < 52) || (r >= 85);
      o = (r >= 52);
      drive(c, p, o, VB'($urandom_range(15)), 1'($urandom), 1'($urandom));
      checks++;
      if (obs_vec() !== model_vec())
        $display("FAIL random cyc%0d: got %h want %h", i, obs_vec(), model_vec());
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_replace();
    test_full();
    test_underflow();
    test_clear();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
